cache_mem_responder: RTL
========================

CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, word-address width (4096 words, 1024 lines).
REQ-002 SHALL have parameter RD_LAT, default 2, legal range 1..15, cycles from read acceptance edge to first ret_valid.
REQ-003 SHALL have parameter BEAT_GAP, default 0, legal range 0..3, idle cycles inserted between consecutive read beats.
REQ-004 SHALL have port clk, input, 1 bit, clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port rd_req, input, 1 bit, read request held by the initiator until accepted.
REQ-007 SHALL have port rd_type, input, 3 bits, read type: 000 byte, 001 half, 010 word, 110 line.
REQ-008 SHALL have port rd_addr, input, 32 bits, read byte address.
REQ-009 SHALL have port rd_rdy, output, 1 bit, read can be accepted this cycle.
REQ-010 SHALL have port ret_valid, output, 1 bit, ret_data valid this cycle.
REQ-011 SHALL have port ret_last, output, 1 bit, final beat of the current read.
REQ-012 SHALL have port ret_data, output, 32 bits, returned word.
REQ-013 SHALL have port wr_req, input, 1 bit, write request.
REQ-014 SHALL have port wr_type, input, 3 bits, write type, same encoding as rd_type.
REQ-015 SHALL have port wr_addr, input, 32 bits, write byte address.
REQ-016 SHALL have port wr_wstrb, input, 4 bits, byte enables for non-line writes.
REQ-017 SHALL have port wr_data, input, 128 bits, write data; bank b at bits [32b+31:32b].
REQ-018 SHALL have port wr_rdy, output, 1 bit, write can be accepted this cycle.
REQ-019 SHALL have port err, output, 1 bit, one-cycle pulse on acceptance of an unsupported type.

Function
REQ-020 Word index SHALL be addr[ADDR_BITS+1:2]; higher address bits ignored (aliasing wrap).
REQ-021 Read FSM SHALL use states R_IDLE, R_WAIT, R_DATA, R_GAP.
REQ-022 rd_rdy SHALL equal (state==R_IDLE) & ~wr_req & ~rst; acceptance is rd_req & rd_rdy.
REQ-023 On acceptance SHALL latch type/address, go to R_WAIT, count RD_LAT-1 cycles, then go to R_DATA.
REQ-024 The first ret_valid SHALL appear exactly RD_LAT cycles after the acceptance edge.
REQ-025 Line read (110) SHALL return 4 beats, banks 0,1,2,3 of the line (addr[3:2] ignored); ret_last on beat 3.
REQ-026 Byte/half/word read SHALL return 1 full aligned word, with ret_last on that beat.
REQ-027 After a non-last beat, BEAT_GAP>0 SHALL insert BEAT_GAP cycles in R_GAP with ret_valid=0.
REQ-028 After the last beat SHALL return to R_IDLE; rd_rdy is high next cycle at the earliest.
REQ-029 ret_data SHALL be a register; it is undefined when ret_valid=0, and ret_last=0 whenever ret_valid=0.
REQ-030 wr_rdy SHALL be ~rst, independent of read state; acceptance is wr_req & wr_rdy.
REQ-031 Line write SHALL commit all 16 bytes at the acceptance edge, ignoring wr_wstrb.
REQ-032 Byte/half/word write SHALL commit wr_data[31:0] to word addr[..:2] under wr_wstrb in the same edge.
REQ-033 Simultaneous rd_req and wr_req in R_IDLE SHALL accept the write only; the read is accepted no earlier than the next cycle.
REQ-034 Each beat SHALL read memory when sampled, so a write committed mid-burst is visible to later beats of the same burst only.
REQ-035 Type not in {000,001,010,110} SHALL pulse err; reads behave as word and writes are dropped.

Reset
REQ-036 On rst: read state R_IDLE; ret_valid, ret_last and err are 0; ret_data is 0; counters are 0; rd_rdy and wr_rdy are 0 while rst is high.
REQ-037 rst asserted mid-burst SHALL abandon the burst, with no further beats after reset releases; memory contents are not reset.

Structure
REQ-038 Shared package cache_if_pkg SHALL hold type codes (RT_BYTE, RT_HALF, RT_WORD, RT_LINE), read-FSM state encodings and line/bank width constants.
REQ-039 The memory SHALL be one sub-module, resp_mem: 4 banks of 32-bit words, byte-enable write port, async read port.

Verification
REQ-040 Write line 0x1C000040 with data 0x44444444_33333333_22222222_11111111, then line-read 0x1C000048 -> beats 11111111, 22222222, 33333333, 44444444; first beat 2 cycles after acceptance; ret_last on beat 4 only.
REQ-041 Word write 0xAABBCCDD with wstrb 0101 to 0x00000004 (old value 0) -> word read returns 0x00BB00DD, single beat with ret_last.
REQ-042 rd_req and wr_req asserted together -> rd_rdy=0 that cycle, write committed, read accepted next cycle and returns the new data.
REQ-043 Test with BEAT_GAP=2, RD_LAT=1 -> beats at cycles 1, 4, 7, 10 after acceptance.
REQ-044 Write during a burst between beats 1 and 2 to the same line -> beats 0-1 return old data, beats 2-3 return new data.
REQ-045 rst pulse after beat 1 -> no ret_valid afterwards; rd_rdy=1 in the first cycle after reset; rd_type 011 -> err pulse, one-beat word read.

Source files
------------

// File: rtl/cache_if_pkg.sv
// Shared definitions for the cache memory responder: access type codes,
// read-FSM state encodings and line/bank geometry.
package cache_if_pkg;

  localparam logic [2:0] RT_BYTE = 3'b000;
  localparam logic [2:0] RT_HALF = 3'b001;
  localparam logic [2:0] RT_WORD = 3'b010;
  localparam logic [2:0] RT_LINE = 3'b110;

  localparam int BANKS  = 4;
  localparam int WORD_W = 32;
  localparam int LINE_W = BANKS * WORD_W;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA, R_GAP} rstate_e;

  // True for the four access types the responder understands.
  function automatic logic type_ok(logic [2:0] t);
    return (t == RT_BYTE) || (t == RT_HALF) || (t == RT_WORD) || (t == RT_LINE);
  endfunction

endpackage

// File: rtl/resp_mem.sv
// Line-organised backing store: BANKS banks of 32-bit words sharing one line
// index, per-byte write enables, asynchronous read of a single bank word.
module resp_mem
  import cache_if_pkg::*;
#(
  parameter int LINE_BITS = 10
) (
  input  logic                           clk_i,
  input  logic [BANKS-1:0][3:0]          we_i,
  input  logic [LINE_BITS-1:0]           waddr_i,
  input  logic [BANKS-1:0][WORD_W-1:0]   wdata_i,
  input  logic [LINE_BITS-1:0]           raddr_i,
  input  logic [1:0]                     rbank_i,
  output logic [WORD_W-1:0]              rdata_o
);

  localparam int DEPTH = 1 << LINE_BITS;

  logic [BANKS-1:0][WORD_W-1:0] rd_words;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [WORD_W-1:0] mem [DEPTH];

    // Byte-lane writes; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
      for (int j = 0; j < 4; j++)
        if (we_i[b][j]) mem[waddr_i][8*j +: 8] <= wdata_i[b][8*j +: 8];
    end

    assign rd_words[b] = mem[raddr_i];
  end

  assign rdata_o = rd_words[rbank_i];

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for a cache: accepts reads (single word or 4-beat
// line bursts with programmable latency and inter-beat gap) and writes that
// commit in the accepting edge. Writes win over reads in the same cycle.
module cache_mem_responder
  import cache_if_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int RD_LAT    = 2,
  parameter int BEAT_GAP  = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         err
);

  localparam int LB = ADDR_BITS - 2;
  localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);
  localparam logic [3:0] GAP_M1 = 4'(BEAT_GAP - 1);

  rstate_e              state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [1:0]           beat_q, beat_d;
  logic [ADDR_BITS-1:0] word_q, word_d;
  logic                 line_q, line_d;
  logic                 ret_valid_q, ret_valid_d;
  logic                 ret_last_q, ret_last_d;
  logic [31:0]          ret_data_q, ret_data_d;
  logic                 err_q, err_d;

  logic                 rd_acc, wr_acc, wr_ok, wr_is_line, load;
  logic [BANKS-1:0][3:0]        mem_we;
  logic [BANKS-1:0][WORD_W-1:0] mem_wdata;
  logic [31:0]          mem_rdata;
  logic                 unused_addr;

  assign rd_rdy     = (state_q == R_IDLE) & ~wr_req & ~rst;
  assign wr_rdy     = ~rst;
  assign rd_acc     = rd_req & rd_rdy;
  assign wr_acc     = wr_req & wr_rdy;
  assign wr_ok      = wr_acc & type_ok(wr_type);
  assign wr_is_line = (wr_type == RT_LINE);

  assign ret_valid = ret_valid_q;
  assign ret_last  = ret_last_q;
  assign ret_data  = ret_data_q;
  assign err       = err_q;

  assign unused_addr = ^{rd_addr[31:ADDR_BITS+2], rd_addr[1:0],
                         wr_addr[31:ADDR_BITS+2], wr_addr[1:0]};

  // Write path: a line write fills every bank; narrower writes hit one bank
  // under the byte strobes with the low word replicated across banks.
  always_comb begin
    mem_we    = '0;
    mem_wdata = '0;
    for (int b = 0; b < BANKS; b++) begin
      mem_wdata[b] = wr_is_line ? wr_data[32*b +: 32] : wr_data[31:0];
      if (wr_ok)
        mem_we[b] = wr_is_line ? 4'hF : ((wr_addr[3:2] == 2'(b)) ? wr_wstrb : 4'h0);
    end
  end

  resp_mem #(.LINE_BITS(LB)) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (wr_addr[ADDR_BITS+1:4]),
    .wdata_i (mem_wdata),
    .raddr_i (word_q[ADDR_BITS-1:2]),
    .rbank_i (line_q ? beat_d : word_q[1:0]),
    .rdata_o (mem_rdata)
  );

  // Read FSM next state; a beat is loaded into the output register on the
  // edge that enters R_DATA, so memory is sampled per beat.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    word_d     = word_q;
    line_d     = line_q;
    ret_data_d = ret_data_q;
    load       = 1'b0;
    err_d      = (rd_acc & ~type_ok(rd_type)) | (wr_acc & ~type_ok(wr_type));
    case (state_q)
      R_IDLE: if (rd_acc) begin
        word_d  = rd_addr[ADDR_BITS+1:2];
        line_d  = (rd_type == RT_LINE);
        cnt_d   = 4'd0;
        beat_d  = 2'd0;
        state_d = R_WAIT;
      end
      R_WAIT: if (cnt_q == LAT_M1) begin
        load    = 1'b1;
        state_d = R_DATA;
      end else cnt_d = cnt_q + 4'd1;
      R_DATA: if (ret_last_q) state_d = R_IDLE;
        else if (BEAT_GAP == 0) begin
          load   = 1'b1;
          beat_d = beat_q + 2'd1;
        end else begin
          cnt_d   = 4'd0;
          state_d = R_GAP;
        end
      R_GAP: if (cnt_q == GAP_M1) begin
        load    = 1'b1;
        beat_d  = beat_q + 2'd1;
        state_d = R_DATA;
      end else cnt_d = cnt_q + 4'd1;
      default: state_d = R_IDLE;
    endcase
    ret_valid_d = load;
    ret_last_d  = load & (~line_q | (beat_d == 2'd3));
    if (load) ret_data_d = mem_rdata;
  end

  // Read FSM and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= R_IDLE;
      cnt_q       <= '0;
      beat_q      <= '0;
      word_q      <= '0;
      line_q      <= 1'b0;
      ret_valid_q <= 1'b0;
      ret_last_q  <= 1'b0;
      ret_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      word_q      <= word_d;
      line_q      <= line_d;
      ret_valid_q <= ret_valid_d;
      ret_last_q  <= ret_last_d;
      ret_data_q  <= ret_data_d;
      err_q       <= err_d;
    end
  end

endmodule
